// File: rtl/magic_device_pkg.sv
// Shared types and default widths for the magic device reader.
// Also provides the per-state output decode used by the FSM.
package magic_device_pkg;

  localparam int SEL_W_DEF  = 12;
  localparam int DATA_W_DEF = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  typedef struct packed {
    logic req_ready;
    logic read_ready;
    logic resp_valid;
    logic busy;
  } ctrl_t;

  // Control outputs that hold for the whole time the FSM sits in state s.
  function automatic ctrl_t state_ctrl(state_t s);
    ctrl_t c;
    c            = '0;
    c.req_ready  = (s == IDLE);
    c.read_ready = (s == ISSUE);
    c.resp_valid = (s == RESP);
    c.busy       = (s != IDLE);
    return c;
  endfunction

endpackage

// File: rtl/magic_device_reader_if.sv
// Core request/response channels and the device-side read port of the reader.
// The slave modport is the reader's view; the master modport drives it.
interface magic_device_reader_if
  import magic_device_pkg::*;
#(
  parameter int SEL_W  = SEL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  logic [SEL_W-1:0]  req_select;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;

  logic [SEL_W-1:0]  read_select;
  logic              read_ready;
  logic              read_valid;
  logic [DATA_W-1:0] read_data;

  modport slave (
    input  req_valid, req_select, resp_ready, read_valid, read_data,
    output req_ready, resp_valid, resp_data, resp_err, read_select, read_ready
  );

  modport master (
    output req_valid, req_select, resp_ready, read_valid, read_data,
    input  req_ready, resp_valid, resp_data, resp_err, read_select, read_ready
  );

endinterface

// File: rtl/magic_device_reader.sv
// Single-outstanding device reader: accepts a select, handshakes the device,
// captures the data one cycle later (or times out) and returns one response.
module magic_device_reader
  import magic_device_pkg::*;
#(
  parameter int SEL_W   = SEL_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255
)(
  input  logic                   clock,
  input  logic                   reset,
  magic_device_reader_if.slave   bus,
  output logic                   busy
);

  localparam int             CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  state_t            r_state;
  ctrl_t             r_ctrl;
  logic [SEL_W-1:0]  r_sel;
  logic [DATA_W-1:0] r_data;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;

  // Control outputs are registered alongside the state: every transition also
  // loads the decode of the state being entered, so they never glitch.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ctrl  <= state_ctrl(IDLE);
      r_sel   <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_sel   <= bus.req_select;
            r_cnt   <= '0;
            r_state <= ISSUE;
            r_ctrl  <= state_ctrl(ISSUE);
          end
        end

        ISSUE: begin
          if (bus.read_valid) begin
            r_cnt   <= '0;
            r_state <= CAPTURE;
            r_ctrl  <= state_ctrl(CAPTURE);
          end else if (r_cnt == TO_VAL) begin
            r_err   <= 1'b1;
            r_data  <= '0;
            r_state <= RESP;
            r_ctrl  <= state_ctrl(RESP);
          end else begin
            // Never passes TO_VAL: the branch above leaves ISSUE first.
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        CAPTURE: begin
          // The device drives its data on the falling edge after the handshake.
          r_data  <= bus.read_data;
          r_err   <= 1'b0;
          r_state <= RESP;
          r_ctrl  <= state_ctrl(RESP);
        end

        RESP: begin
          if (bus.resp_ready) begin
            r_state <= IDLE;
            r_ctrl  <= state_ctrl(IDLE);
          end
        end

        default: begin
          r_state <= IDLE;
          r_ctrl  <= state_ctrl(IDLE);
        end
      endcase
    end
  end

  assign bus.req_ready   = r_ctrl.req_ready;
  assign bus.read_ready  = r_ctrl.read_ready;
  assign bus.resp_valid  = r_ctrl.resp_valid;
  assign bus.read_select = r_sel;
  assign bus.resp_data   = r_data;
  assign bus.resp_err    = r_err;
  assign busy            = r_ctrl.busy;

endmodule

// File: tb/tb_magic_device_reader.sv
// Bench for magic_device_reader: table-driven reads plus hand-written timeout,
// back-to-back and mid-transaction reset sequences, with a response scoreboard.
module tb_magic_device_reader;

  logic clk;
  logic rst;
  logic busy_a;
  logic busy_b;

  int n_checks = 0;
  int n_errors = 0;

  magic_device_reader_if #(.SEL_W(12), .DATA_W(64)) bus_a ();
  magic_device_reader_if #(.SEL_W(12), .DATA_W(64)) bus_b ();

  magic_device_reader #(.SEL_W(12), .DATA_W(64), .TIMEOUT(255)) dut_a (
    .clock (clk),
    .reset (rst),
    .bus   (bus_a),
    .busy  (busy_a)
  );

  magic_device_reader #(.SEL_W(12), .DATA_W(64), .TIMEOUT(4)) dut_b (
    .clock (clk),
    .reset (rst),
    .bus   (bus_b),
    .busy  (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Device model for dut_a: data is valid only for the cycle after a handshake.
  logic hs_a = 1'b0;
  int   hs_cnt_a = 0;

  always @(posedge clk) begin
    hs_a     <= bus_a.read_ready && bus_a.read_valid;
    hs_cnt_a <= hs_cnt_a + ((bus_a.read_ready && bus_a.read_valid) ? 1 : 0);
  end

  function automatic logic [63:0] dev_data(input logic [11:0] sel);
    return {32'hDEAD_BEEF, 20'h0, sel};
  endfunction

  always @(negedge clk)
    bus_a.read_data <= hs_a ? dev_data(bus_a.read_select) : 64'h0BAD_0BAD_0BAD_0BAD;

  typedef struct {
    logic [63:0] data;
    logic        err;
  } resp_t;

  resp_t sb_q[$];

  typedef struct {
    logic [11:0] sel;
    int          vdelay;
    int          bp;
    int          lat;
    logic [63:0] data;
    logic        err;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_push(input logic [63:0] data, input logic err);
    resp_t e;
    e.data = data;
    e.err  = err;
    sb_q.push_back(e);
  endtask

  // Called on the cycle where resp_ready is about to complete the handshake.
  task automatic sb_pop();
    resp_t e;
    check("resp_valid at handshake", 64'(bus_a.resp_valid), 64'd1);
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_empty: got response %h expected none", bus_a.resp_data);
    end else begin
      e = sb_q.pop_front();
      check("resp_data", bus_a.resp_data, e.data);
      check("resp_err", 64'(bus_a.resp_err), 64'(e.err));
    end
  endtask

  task automatic run_vec(input vec_t v);
    int c;
    int hs0;
    check("req_ready before request", 64'(bus_a.req_ready), 64'd1);
    bus_a.req_valid  = 1'b1;
    bus_a.req_select = v.sel;
    bus_a.read_valid = (v.vdelay == 0);
    bus_a.resp_ready = 1'b0;
    sb_push(v.data, v.err);
    hs0 = hs_cnt_a;
    @(negedge clk);
    bus_a.req_valid = 1'b0;
    c = 1;
    check("read_select in ISSUE", 64'(bus_a.read_select), 64'(v.sel));
    check("read_ready in ISSUE", 64'(bus_a.read_ready), 64'd1);
    check("busy in ISSUE", 64'(busy_a), 64'd1);
    while (!bus_a.resp_valid && c < 300) begin
      if (c >= v.vdelay + 1) bus_a.read_valid = 1'b1;
      @(negedge clk);
      c++;
    end
    check("latency", 64'(c), 64'(v.lat));
    for (int i = 0; i < v.bp; i++) begin
      check("bp resp_valid", 64'(bus_a.resp_valid), 64'd1);
      check("bp resp_data", bus_a.resp_data, v.data);
      check("bp req_ready", 64'(bus_a.req_ready), 64'd0);
      check("bp read_ready", 64'(bus_a.read_ready), 64'd0);
      @(negedge clk);
    end
    sb_pop();
    bus_a.resp_ready = 1'b1;
    @(negedge clk);
    bus_a.resp_ready = 1'b0;
    bus_a.read_valid = 1'b0;
    check("resp_valid after handshake", 64'(bus_a.resp_valid), 64'd0);
    check("req_ready after handshake", 64'(bus_a.req_ready), 64'd1);
    check("busy after handshake", 64'(busy_a), 64'd0);
    check("device handshakes", 64'(hs_cnt_a - hs0), 64'd1);
  endtask

  // dut_b has TIMEOUT=4 and a device that never answers.
  task automatic run_timeout(input logic [11:0] sel);
    int c;
    check("tmo req_ready", 64'(bus_b.req_ready), 64'd1);
    bus_b.req_valid  = 1'b1;
    bus_b.req_select = sel;
    @(negedge clk);
    bus_b.req_valid = 1'b0;
    c = 1;
    while (!bus_b.resp_valid && c < 100) begin
      if (c == 5) check("tmo read_ready last ISSUE", 64'(bus_b.read_ready), 64'd1);
      @(negedge clk);
      c++;
    end
    check("tmo latency", 64'(c), 64'd6);
    check("tmo read_ready in RESP", 64'(bus_b.read_ready), 64'd0);
    check("tmo resp_err", 64'(bus_b.resp_err), 64'd1);
    check("tmo resp_data", bus_b.resp_data, 64'd0);
    check("tmo read_select", 64'(bus_b.read_select), 64'(sel));
    bus_b.resp_ready = 1'b1;
    @(negedge clk);
    bus_b.resp_ready = 1'b0;
    check("tmo busy after", 64'(busy_b), 64'd0);
  endtask

  task automatic run_back_to_back();
    check("b2b req_ready idle", 64'(bus_a.req_ready), 64'd1);
    bus_a.req_valid  = 1'b1;
    bus_a.req_select = 12'h001;
    bus_a.read_valid = 1'b1;
    bus_a.resp_ready = 1'b1;
    sb_push(64'hDEAD_BEEF_0000_0001, 1'b0);
    @(negedge clk);
    bus_a.req_select = 12'h002;
    check("b2b req_ready ISSUE", 64'(bus_a.req_ready), 64'd0);
    @(negedge clk);
    check("b2b resp_valid CAPTURE", 64'(bus_a.resp_valid), 64'd0);
    @(negedge clk);
    check("b2b req_ready RESP", 64'(bus_a.req_ready), 64'd0);
    sb_pop();
    @(negedge clk);
    check("b2b req_ready IDLE gap", 64'(bus_a.req_ready), 64'd1);
    check("b2b resp_valid IDLE gap", 64'(bus_a.resp_valid), 64'd0);
    sb_push(64'hDEAD_BEEF_0000_0002, 1'b0);
    @(negedge clk);
    bus_a.req_valid = 1'b0;
    check("b2b req2 accepted", 64'(bus_a.read_select), 64'h002);
    check("b2b req_ready after accept", 64'(bus_a.req_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    sb_pop();
    @(negedge clk);
    bus_a.resp_ready = 1'b0;
    bus_a.read_valid = 1'b0;
    check("b2b busy end", 64'(busy_a), 64'd0);
  endtask

  task automatic run_reset_mid_issue();
    int seen;
    int hs0;
    bus_a.req_valid  = 1'b1;
    bus_a.req_select = 12'h005;
    bus_a.read_valid = 1'b0;
    bus_a.resp_ready = 1'b0;
    @(negedge clk);
    bus_a.req_valid = 1'b0;
    check("rst busy in ISSUE", 64'(busy_a), 64'd1);
    rst = 1'b1;
    #1;
    check("rst busy", 64'(busy_a), 64'd0);
    check("rst req_ready", 64'(bus_a.req_ready), 64'd1);
    check("rst read_ready", 64'(bus_a.read_ready), 64'd0);
    check("rst read_select", 64'(bus_a.read_select), 64'd0);
    check("rst resp_valid", 64'(bus_a.resp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus_a.read_valid = 1'b1;
    hs0  = hs_cnt_a;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_a.resp_valid || busy_a) seen++;
    end
    bus_a.read_valid = 1'b0;
    check("no spurious activity after reset", 64'(seen), 64'd0);
    check("no handshake after reset", 64'(hs_cnt_a - hs0), 64'd0);
  endtask

  initial begin
    vecs[0] = '{12'h00A, 0, 0, 3, 64'hDEAD_BEEF_0000_000A, 1'b0};
    vecs[1] = '{12'h0FF, 0, 5, 3, 64'hDEAD_BEEF_0000_00FF, 1'b0};
    vecs[2] = '{12'h123, 2, 0, 5, 64'hDEAD_BEEF_0000_0123, 1'b0};
    vecs[3] = '{12'hFFF, 1, 2, 4, 64'hDEAD_BEEF_0000_0FFF, 1'b0};

    rst = 1'b1;
    bus_a.req_valid  = 1'b0;
    bus_a.req_select = '0;
    bus_a.resp_ready = 1'b0;
    bus_a.read_valid = 1'b0;
    bus_b.req_valid  = 1'b0;
    bus_b.req_select = '0;
    bus_b.resp_ready = 1'b0;
    bus_b.read_valid = 1'b0;
    bus_b.read_data  = 64'h1234_5678_9ABC_DEF0;

    @(negedge clk);
    check("reset req_ready", 64'(bus_a.req_ready), 64'd1);
    check("reset resp_valid", 64'(bus_a.resp_valid), 64'd0);
    check("reset resp_data", bus_a.resp_data, 64'd0);
    check("reset resp_err", 64'(bus_a.resp_err), 64'd0);
    check("reset read_ready", 64'(bus_a.read_ready), 64'd0);
    check("reset read_select", 64'(bus_a.read_select), 64'd0);
    check("reset busy", 64'(busy_a), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);
    run_timeout(12'h003);
    run_timeout(12'h004);
    run_back_to_back();
    run_reset_mid_issue();

    check("scoreboard drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/magic_device_reader.md
MAGIC_DEVICE_READER -- requirements
Module: magic_device_reader

Interface
REQ-001 SHALL have parameter SEL_W, default 12, the device read-select width.
REQ-002 SHALL have parameter DATA_W, default 64, the device data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, the maximum number of cycles to wait for read_valid (range 1..65535).
REQ-004 SHALL have port clock  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports req_valid in 1 / req_ready out 1 / req_select in SEL_W: the core-side read request channel.
REQ-007 SHALL have ports resp_valid out 1 / resp_ready in 1 / resp_data out DATA_W / resp_err out 1: the core-side response channel.
REQ-008 SHALL have ports read_select out SEL_W / read_ready out 1 / read_valid in 1 / read_data in DATA_W: the device-side initiator port.
REQ-009 SHALL have port busy  out  1, high whenever the FSM is not IDLE.

Function
REQ-010 SHALL implement a four-state FSM: IDLE, ISSUE, CAPTURE, RESP.
REQ-011 IDLE: req_ready=1; when req_valid is high, latch req_select into sel_q and go to ISSUE.
REQ-012 ISSUE: read_ready=1 and read_select=sel_q; when read_valid is high (handshake), clear the timeout counter and go to CAPTURE.
REQ-013 ISSUE: when read_valid is low, increment the timeout counter; when the count equals TIMEOUT, set err_q=1, set data_q=0 and go to RESP without a handshake.
REQ-014 CAPTURE: read_ready=0; sample read_data into data_q at the end of this cycle, since the device updates its data on the falling edge after the handshake; set err_q=0 and go to RESP.
REQ-015 RESP: resp_valid=1, resp_data=data_q, resp_err=err_q; when resp_ready is high, go to IDLE.
REQ-016 SHALL have a minimum latency from request acceptance to resp_valid of 3 cycles when read_valid is already high.
REQ-017 resp_data and resp_err SHALL hold stable while resp_valid=1 and resp_ready=0.
REQ-018 req_ready SHALL be 0 in every state except IDLE; there is no request queuing.
REQ-019 read_select SHALL hold sel_q in all states, so it changes only when a request is accepted.
REQ-020 read_ready SHALL be asserted only in ISSUE, so exactly one device handshake occurs per non-timeout request.
REQ-021 The timeout counter SHALL be clog2(TIMEOUT+1) bits wide and SHALL saturate without wrapping.
REQ-022 A request arriving while the block is in RESP SHALL stall (req_ready=0) until the cycle after the response handshake.
REQ-023 SHALL provide no back-to-back bypass: the IDLE cycle is mandatory between requests.

Reset
REQ-024 Reset SHALL asynchronously force state=IDLE, sel_q=0, data_q=0, err_q=0 and timeout counter=0.
REQ-025 During reset, outputs SHALL be: req_ready=1, resp_valid=0, resp_data=0, resp_err=0, read_ready=0, read_select=0, busy=0.
REQ-026 Reset asserted mid-transaction SHALL drop that transaction silently; no response SHALL be produced after reset deasserts.

Structure
REQ-027 Package magic_device_pkg SHALL hold the FSM state enum and the default SEL_W and DATA_W constants.
REQ-028 SHALL be a single flat module with no sub-modules; the timeout counter stays inline.

Verification
REQ-029 Basic read: read_valid tied to 1, req_select=12'h00A, device returns 64'hDEAD_BEEF_0000_000A -> resp_valid 3 cycles after acceptance, resp_data=64'hDEAD_BEEF_0000_000A, resp_err=0.
REQ-030 Response backpressure: resp_ready held low for 5 cycles -> resp_valid/resp_data stable for 5 cycles; req_ready=0 throughout; exactly one read_ready handshake.
REQ-031 Timeout: TIMEOUT=4, read_valid=0 -> resp_valid after 1+4+1 cycles with resp_err=1, resp_data=0; read_ready drops on entry to RESP.
REQ-032 Late valid: read_valid rises on the 3rd ISSUE cycle with TIMEOUT=255 -> resp_err=0 and the correct data is captured.
REQ-033 Reset mid-ISSUE: assert reset for 1 cycle while in ISSUE -> next cycle state=IDLE, busy=0, and no spurious resp_valid for 10 cycles.
REQ-034 Back-to-back: two requests (select 1, then 2) with resp_ready=1 -> responses in order; request 2 is accepted exactly 1 cycle after response 1.
